// File: rtl/zd_pkg.sv
// zd_pkg: shared constants, FSM encoding and stage power decode for the zero-detector sequencer
package zd_pkg;

    localparam int ZD_WIDTH    = 16;
    localparam int ZD_NSTAGE   = 7;
    localparam int ZD_NQUARTER = 4;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } zd_fsm_t;

    // A stage is powered in its evaluate quarter (q == stage) and its hold quarter (q == stage+1), mod 4
    function automatic logic stage_powered(input logic [2:0] stage, input logic [ZD_NQUARTER-1:0] q);
        logic [1:0] s;
        s = stage[1:0];
        return q[s] | q[s + 2'd1];
    endfunction

endpackage

// File: rtl/zd_result_fifo.sv
// zd_result_fifo: 2-entry 1-bit result queue, head always at mem[0]
module zd_result_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       din,
    output logic       dout,
    output logic [1:0] count
);

    logic [1:0] mem;
    logic       wi;

    assign wi   = count[0] ^ pop;
    assign dout = mem[0];

    // shift toward the head on pop; the push lands just behind the surviving entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            count <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop) mem[0] <= mem[1];
            if (push) mem[wi] <= din;
        end
    end

endmodule

// File: rtl/zd_phase_sequencer.sv
// zd_phase_sequencer: four-phase power-clock generator, operand launch and result capture for zero_detector
module zd_phase_sequencer
    import zd_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [ZD_WIDTH-1:0]  op_a,
    input  logic [ZD_WIDTH-1:0]  op_b,
    output logic [ZD_WIDTH-1:0]  zd_a,
    output logic [ZD_WIDTH-1:0]  zd_b,
    output logic [ZD_NSTAGE-1:0] clkpos,
    output logic [ZD_NSTAGE-1:0] clkneg,
    input  logic                 zd_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_eq
);

    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

    logic [DW-1:0]          d;
    logic [ZD_NQUARTER-1:0] q;
    logic [ZD_NQUARTER-1:0] q_nxt;
    zd_fsm_t                st;
    logic                   inflight;
    logic                   last_d;
    logic                   slot;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [1:0]             fifo_count;
    logic [ZD_NSTAGE-1:0]   pos_nxt;

    assign last_d    = d == DW'(DIV - 1);
    assign slot      = last_d && q[ZD_NQUARTER-1];
    assign q_nxt     = last_d ? {q[ZD_NQUARTER-2:0], q[ZD_NQUARTER-1]} : q;
    // credit counts only registered occupancy, so a same-cycle pop never opens the gate
    assign op_ready  = rst_n && slot && (fifo_count + 2'(inflight)) <= 2'd1;
    assign accept    = op_valid && op_ready;
    assign push      = slot && inflight;
    assign pop       = res_valid && res_ready;
    assign res_valid = fifo_count != 2'd0;

    // decode of the upcoming quarter; clocks stay parked until the warm quarter ends
    always_comb begin
        pos_nxt = '0;
        if (st == RUN || last_d)
            for (int i = 0; i < ZD_NSTAGE; i++) pos_nxt[i] = stage_powered(3'(i), q_nxt);
    end

    // divider, one-hot quarter rotation and warm-up exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d  <= '0;
            q  <= 4'b1000;
            st <= WARM;
        end else begin
            d <= last_d ? '0 : d + DW'(1);
            q <= q_nxt;
            if (last_d) st <= RUN;
        end
    end

    // power clocks come straight from flops so the ports never see decode glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkpos <= '0;
            clkneg <= '1;
        end else begin
            clkpos <= pos_nxt;
            clkneg <= ~pos_nxt;
        end
    end

    // operand launch and in-flight tracking; an accept on a sample edge re-arms inflight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zd_a     <= '0;
            zd_b     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept | (inflight & ~slot);
            if (accept) begin
                zd_a <= op_a;
                zd_b <= op_b;
            end
        end
    end

    zd_result_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (zd_out),
        .dout  (res_eq),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_zd_phase_sequencer.sv
// tb_zd_phase_sequencer: directed scoreboard bench for DIV=4 and DIV=1 sequencers
module tb_zd_phase_sequencer;

    typedef struct {
        logic eq;
        int   due;
    } exp_t;

    logic        clk = 0;
    logic        rst_n, op_valid, op_ready, zd_out, res_valid, res_ready, res_eq;
    logic [15:0] op_a, op_b, zd_a, zd_b;
    logic [6:0]  clkpos, clkneg;

    logic        rst1_n, v1, rdy1, zo1, rv1, rr1, re1;
    logic [15:0] a1, b1, za1, zb1;
    logic [6:0]  cp1, cn1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   k;
    exp_t sb[$];
    exp_t sb1[$];
    logic [15:0] pa[3] = '{16'hFFFF, 16'h0001, 16'h8000};
    logic [15:0] pb[3] = '{16'hFFFF, 16'h0000, 16'h8000};

    always #5 clk = ~clk;

    // behavioural detector: output only meaningful while the last stage is powered
    assign zd_out = clkpos[6] ? (zd_a == zd_b) : 1'b0;
    assign zo1    = cp1[6] ? (za1 == zb1) : 1'b0;

    zd_phase_sequencer #(.DIV(4)) u4 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .zd_a(zd_a), .zd_b(zd_b),
        .clkpos(clkpos), .clkneg(clkneg), .zd_out(zd_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_eq(res_eq)
    );

    zd_phase_sequencer #(.DIV(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .op_valid(v1), .op_ready(rdy1),
        .op_a(a1), .op_b(b1), .zd_a(za1), .zd_b(zb1),
        .clkpos(cp1), .clkneg(cn1), .zd_out(zo1),
        .res_valid(rv1), .res_ready(rr1), .res_eq(re1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected power-clock pattern at cycle c after release, from the quarter rule
    function automatic logic [6:0] exp_pos(input int c, input int div);
        logic [6:0] r;
        int qq;
        r = '0;
        if (c < div) return r;
        qq = ((c - div) / div) % 4;
        for (int i = 0; i < 7; i++) r[i] = (((qq - i) % 4 + 4) % 4) < 2;
        return r;
    endfunction

    task automatic tick();
        logic acc, pp, eqv, rv, e;
        exp_t x;
        acc = op_valid && op_ready;
        pp  = res_valid && res_ready;
        eqv = res_eq;
        rv  = res_valid;
        e   = (op_a == op_b);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (pp) begin
                if (sb.size() == 0) chk("pop_unexpected", 32'(pp), 32'(0));
                else begin
                    x = sb.pop_front();
                    chk("res_eq", 32'(eqv), 32'(x.eq));
                end
            end
            if (acc) sb.push_back('{e, cyc + 16});
            if (!rv && res_valid) begin
                if (sb.size() == 0) chk("spurious_result", 32'(res_valid), 32'(0));
                else chk("res_time", 32'(cyc), 32'(sb[0].due));
            end
            chk("clkneg_inv", 32'(clkneg ^ clkpos), 32'h7f);
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        sb.delete();
        op_valid = 0;
        res_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cyc = 0;
    endtask

    initial begin
        exp_t x;
        rst_n = 0; op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
        rst1_n = 0; v1 = 0; a1 = 0; b1 = 0; rr1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_eq", 32'(res_eq), 32'(0));
        chk("rst_zd_a", 32'(zd_a), 32'(0));
        chk("rst_zd_b", 32'(zd_b), 32'(0));
        chk("rst_clkpos", 32'(clkpos), 32'(0));
        chk("rst_clkneg", 32'(clkneg), 32'h7f);

        // reset release, waveform and a single equal operand pair
        rst_n = 1;
        cyc = 0;
        for (int c = 0; c <= 21; c++) begin
            op_valid = (c == 3);
            op_a = 16'h1234;
            op_b = 16'h1234;
            res_ready = (c >= 20);
            #1;
            chk("p1_clkpos", 32'(clkpos), 32'(exp_pos(c, 4)));
            chk("p1_op_ready", 32'(op_ready), 32'(c % 16 == 3));
            chk("p1_zd_a", 32'(zd_a), c >= 4 ? 32'h1234 : 32'h0);
            chk("p1_res_valid", 32'(res_valid), 32'(c == 20));
            if (c == 20) chk("p1_res_eq", 32'(res_eq), 32'(1));
            tick();
        end

        // back-to-back at full rate
        do_reset();
        res_ready = 1;
        k = 0;
        for (int c = 0; c <= 55; c++) begin
            op_valid = k < 3;
            op_a = k < 3 ? pa[k] : 16'h0;
            op_b = k < 3 ? pb[k] : 16'h0;
            #1;
            chk("p2_op_ready", 32'(op_ready), 32'(c % 16 == 3));
            chk("p2_res_valid", 32'(res_valid), 32'(c == 20 || c == 36 || c == 52));
            if (op_valid && op_ready) begin
                chk("p2_accept_cycle", 32'(c), 32'(3 + 16 * k));
                k++;
            end
            tick();
        end
        chk("p2_accepts", 32'(k), 32'(3));
        chk("p2_drained", 32'(sb.size()), 32'(0));

        // backpressure: FIFO fills to two, then drains in order
        do_reset();
        op_valid = 1;
        k = 0;
        for (int c = 0; c <= 70; c++) begin
            op_a = 16'h00A0 + 16'(k);
            op_b = (k % 2 == 1) ? (op_a ^ 16'h0001) : op_a;
            res_ready = (c >= 40);
            #1;
            chk("p3_op_ready", 32'(op_ready), 32'(c == 3 || c == 19 || c == 51 || c == 67));
            chk("p3_res_valid", 32'(res_valid), 32'((c >= 20 && c <= 41) || c == 68));
            if (op_valid && op_ready) k++;
            tick();
        end

        // reset with one buffered result and one in flight
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            op_valid = (c == 3 || c == 19);
            op_a = 16'h5A5A;
            op_b = 16'h5A5A;
            #1;
            if (c < 25) tick();
        end
        chk("p4_pre_res_valid", 32'(res_valid), 32'(1));
        rst_n = 0;
        #1;
        chk("p4_res_valid", 32'(res_valid), 32'(0));
        chk("p4_clkpos", 32'(clkpos), 32'(0));
        chk("p4_clkneg", 32'(clkneg), 32'h7f);
        chk("p4_op_ready", 32'(op_ready), 32'(0));
        chk("p4_zd_a", 32'(zd_a), 32'(0));
        do_reset();
        res_ready = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            chk("p4_no_stale", 32'(res_valid), 32'(0));
            tick();
        end

        // DIV=1: one-cycle quarters
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst1_n = 1;
        rr1 = 1;
        v1 = 1;
        for (int c = 0; c <= 31; c++) begin
            a1 = 16'(c * 37 + 5);
            b1 = (c % 8 == 0) ? a1 : (a1 ^ 16'h0100);
            #1;
            chk("d1_clkpos", 32'(cp1), 32'(exp_pos(c, 1)));
            chk("d1_clkneg", 32'(cn1 ^ exp_pos(c, 1)), 32'h7f);
            chk("d1_op_ready", 32'(rdy1), 32'(c % 4 == 0));
            chk("d1_res_valid", 32'(rv1), 32'(c >= 5 && c % 4 == 1));
            if (rv1) begin
                if (sb1.size() == 0) chk("d1_spurious", 32'(rv1), 32'(0));
                else begin
                    x = sb1.pop_front();
                    chk("d1_res_eq", 32'(re1), 32'(x.eq));
                    chk("d1_res_time", 32'(c), 32'(x.due));
                end
            end
            if (v1 && rdy1) sb1.push_back('{a1 == b1, c + 5});
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
